uart_tx_arbiter: RTL

//  Shares the single UART transmit path between N_REQ requesters (robot command sources).

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART TX arbiter: FSM states, frame fields, SOF default, checksum helper.
// Pure declarations, no logic of its own.
package uart_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_ID, ST_PAY, ST_CHK} state_t;

  typedef enum logic [1:0] {FLD_SOF, FLD_ID, FLD_PAY, FLD_CHK} field_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hAA;

  function automatic logic [7:0] chk_xor(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // IDLE carries no field; callers gate it with tx_valid
  function automatic field_t field_of(input state_t s);
    case (s)
      ST_ID:   return FLD_ID;
      ST_PAY:  return FLD_PAY;
      ST_CHK:  return FLD_CHK;
      default: return FLD_SOF;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req strictly after ptr, wrapping at N.
// Zero latency; no flow control.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [IW-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX byte stream; frame = SOF, ID, payload, XOR checksum.
// tx_valid one cycle after grant; all outputs hold while tx_ready is low, no timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int          N_REQ         = 4,
  parameter int          PAYLOAD_BYTES = 4,
  parameter logic [7:0]  SOF           = SOF_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 req,
  input  logic [N_REQ*PAYLOAD_BYTES*8-1:0] payload,
  output logic [N_REQ-1:0]                 done,
  output logic [2:0]                       grant_id,
  output logic                             busy,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready
);

  localparam int IW  = $clog2(N_REQ);
  localparam int PBW = PAYLOAD_BYTES * 8;
  localparam int CW  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr, arb_idx;
  logic [N_REQ-1:0] arb_gnt;
  logic             arb_any;
  logic [PBW-1:0]   pay_q, sel_pay;
  logic [CW-1:0]    cnt;
  logic [7:0]       chk;
  logic             xfer, last_pay;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    sel_pay = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) sel_pay = payload[i*PBW +: PBW];
    end
  end

  assign xfer     = tx_valid & tx_ready;
  assign last_pay = (cnt == CW'(PAYLOAD_BYTES - 1));
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = '0;
    case (state)
      ST_IDLE: if (arb_any)               state_nxt = ST_SOF;
      ST_SOF:  if (tx_ready)              state_nxt = ST_ID;
      ST_ID:   if (tx_ready)              state_nxt = ST_PAY;
      ST_PAY:  if (tx_ready && last_pay)  state_nxt = ST_CHK;
      ST_CHK:  if (tx_ready)              state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE) begin
      tx_valid = 1'b1;
      case (field_of(state))
        FLD_SOF: tx_data = SOF;
        FLD_ID:  tx_data = {5'b0, grant_id};
        FLD_PAY: tx_data = pay_q[7:0];
        FLD_CHK: tx_data = chk;
        default: tx_data = '0;
      endcase
    end
  end

  // Payload is a shift register: the current byte is always the low byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id <= '0;
      ptr      <= IW'(N_REQ - 1);
      pay_q    <= '0;
      cnt      <= '0;
      chk      <= '0;
      done     <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: if (arb_any) begin
          grant_id <= 3'(arb_idx);
          pay_q    <= sel_pay;
        end
        ST_ID: if (xfer) begin
          cnt <= '0;
          chk <= {5'b0, grant_id};
        end
        ST_PAY: if (xfer) begin
          pay_q <= pay_q >> 8;
          cnt   <= cnt + CW'(1);
          chk   <= chk_xor(chk, pay_q[7:0]);
        end
        ST_CHK: if (xfer) begin
          done <= N_REQ'(1) << grant_id;
          ptr  <= grant_id[IW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
